// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: control FSM for the multi-cycle RV32I CPU.
// Sequences IF/ID/EX/MEM/WB over a shared datapath and one unified memory,
// waits on mem_ready, aborts on memory timeout or illegal opcode, and halts
// on ecall when x17 == 10.
//
// Handshake: mem_ready is a completion strobe from memory. mem_read and
// mem_write are held stable in IF/MEM until mem_ready is seen high on a
// rising clock edge; only then does the access count as done.
//
// Optional feature: define PERF_CNT_EN to add the cycle_cnt and instret_cnt
// performance counter outputs.
module multicycle_ctrl_fsm #(
    parameter int WAIT_CNT_W = 4,
    parameter int MAX_WAIT   = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        halt_req,
    input  logic        alu_bcond,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        pc_source,
    output logic [2:0]  state,
    output logic        is_halted,
    output logic        mem_timeout,
    output logic        illegal_inst
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE= 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    state_t                cur_state;
    state_t                next_state;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    logic rdy;
    logic in_mem_phase;
    logic wait_expired;
    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_ecall;
    logic is_legal_ex;
    logic illegal_hit;
    logic ecall_halt;

    // mem_ready is masked while reset is held so no write strobe can leak out
    assign rdy          = mem_ready & reset;
    assign in_mem_phase = (cur_state == S_IF) || (cur_state == S_MEM);
    assign wait_expired = in_mem_phase && !rdy &&
                          (wait_cnt == WAIT_CNT_W'(MAX_WAIT - 1));

    assign is_r        = (opcode == OP_R);
    assign is_i        = (opcode == OP_I);
    assign is_load     = (opcode == OP_LOAD);
    assign is_store    = (opcode == OP_STORE);
    assign is_branch   = (opcode == OP_BR);
    assign is_jal      = (opcode == OP_JAL);
    assign is_jalr     = (opcode == OP_JALR);
    assign is_ecall    = (opcode == OP_SYS);
    assign is_legal_ex = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr;

    assign illegal_hit = (cur_state == S_ID) && !is_ecall && !is_legal_ex;
    assign ecall_halt  = (cur_state == S_ID) && is_ecall && halt_req;

    assign state = cur_state;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_state <= S_IF;
        else        cur_state <= next_state;
    end

    // Next-state decode; a late mem_ready beats a timeout in the same cycle
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_IF: begin
                if (rdy)               next_state = S_ID;
                else if (wait_expired) next_state = S_HALT;
            end
            S_ID: begin
                if (is_ecall)          next_state = halt_req ? S_HALT : S_IF;
                else if (is_legal_ex)  next_state = S_EX;
                else                   next_state = S_HALT;
            end
            S_EX: begin
                if (is_load || is_store) next_state = S_MEM;
                else if (is_branch)      next_state = S_IF;
                else                     next_state = S_WB;
            end
            S_MEM: begin
                if (rdy)               next_state = is_load ? S_WB : S_IF;
                else if (wait_expired) next_state = S_HALT;
            end
            S_WB:    next_state = S_IF;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_IF;
        endcase
    end

    // Memory wait counter: counts stalled IF/MEM cycles, clears otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (in_mem_phase && !rdy && !wait_expired)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    // Registered halt indicator and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_halted    <= 1'b0;
            mem_timeout  <= 1'b0;
            illegal_inst <= 1'b0;
        end else begin
            is_halted    <= (next_state == S_HALT);
            mem_timeout  <= mem_timeout | wait_expired;
            illegal_inst <= illegal_inst | illegal_hit;
        end
    end

    // Moore strobe decode of state/opcode, with mem_ready/alu_bcond qualifiers
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        i_or_d    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        pc_source = 1'b0;
        case (cur_state)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = rdy;
                ir_write  = rdy;
            end
            S_ID: begin
                alu_src_b = 2'b10;
            end
            S_EX: begin
                if (is_r) begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end else if (is_i) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b10;
                end else if (is_load || is_store) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end else if (is_branch) begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_source = 1'b1;
                    pc_write  = alu_bcond;
                end else if (is_jal) begin
                    pc_source = 1'b1;
                    pc_write  = 1'b1;
                end else if (is_jalr) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = is_load;
                mem_write = is_store;
            end
            S_WB: begin
                reg_write = 1'b1;
                if (is_load)              wb_sel = 2'b01;
                else if (is_jal || is_jalr) wb_sel = 2'b10;
            end
            default: ;
        endcase
    end

`ifdef PERF_CNT_EN
    logic retire;

    // An instruction retires when control returns to IF, or when ecall halts
    assign retire = ((next_state == S_IF) &&
                     (cur_state inside {S_ID, S_EX, S_MEM, S_WB})) || ecall_halt;

    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (cur_state != S_HALT) cycle_cnt   <= cycle_cnt + 32'd1;
            if (retire)              instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm: directed vector table, hand-written
// corner sequences and randomized instruction streams against a
// per-instruction reference model.
module tb_multicycle_ctrl_fsm;

  localparam int MAX_WAIT = 12;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        halt_req, alu_bcond, mem_ready;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0]  wb_sel, alu_src_b, alu_op;
  logic        alu_src_a, pc_source;
  logic [2:0]  state;
  logic        is_halted, mem_timeout, illegal_inst;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .halt_req(halt_req),
    .alu_bcond(alu_bcond), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state(state),
    .is_halted(is_halted), .mem_timeout(mem_timeout), .illegal_inst(illegal_inst)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- observation / stimulus records ----------------
  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, iord, mr, mw, rw;
    logic [1:0] wb;
    logic       a;
    logic [1:0] b;
    logic [1:0] op;
    logic       ps;
    logic       halted, tmo, ill;
  } obs_t;

  typedef struct packed {
    logic [6:0] op;
    logic       hr, bc, rdy;
  } stim_t;

  typedef struct {
    logic [6:0]  op;
    logic        bc;
    logic        rdy;
    logic [10:0] exp;   // {state, pc_write, ir_write, mem_read, mem_write, reg_write, wb_sel, pc_source}
  } vec_t;

  stim_t       stim_q[$];
  logic [19:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          m_tmo, m_ill;
  int          m_cycles, m_instret;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st = state;      o.pcw = pc_write;   o.irw = ir_write; o.iord = i_or_d;
    o.mr = mem_read;   o.mw = mem_write;   o.rw = reg_write; o.wb = wb_sel;
    o.a = alu_src_a;   o.b = alu_src_b;    o.op = alu_op;    o.ps = pc_source;
    o.halted = is_halted; o.tmo = mem_timeout; o.ill = illegal_inst;
    return o;
  endfunction

  function automatic logic [10:0] key_fields();
    return {state, pc_write, ir_write, mem_read, mem_write, reg_write, wb_sel, pc_source};
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
  endfunction

  // ---------------- reference model ----------------
  // Expected observation for a cycle spent in stage st, before stage details.
  function automatic obs_t blank(input logic [2:0] st);
    obs_t o = '0;
    o.st     = st;
    o.halted = (st == 3'd5);
    o.tmo    = m_tmo;
    o.ill    = m_ill;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o = '0;
    o.mr = 1'b1;
    o.b  = 2'b01;
    return o;
  endfunction

  task automatic push(input logic [6:0] op, input logic hr, input logic bc,
                      input logic rdy, input obs_t o);
    stim_t s;
    s.op = op; s.hr = hr; s.bc = bc; s.rdy = rdy;
    stim_q.push_back(s);
    exp_q.push_back(o);
    if (o.st != 3'd5) m_cycles++;
  endtask

  // A memory access stage (IF or MEM): `waits` stalled cycles, then completion.
  task automatic mem_stage(input logic [6:0] op, input logic [2:0] st, input int waits,
                           input logic rd, input logic wr, output bit timed_out);
    obs_t o = blank(st);
    o.mr = rd;
    o.mw = wr;
    if (st == 3'd0) o.b = 2'b01;
    else            o.iord = 1'b1;
    timed_out = 1'b0;
    for (int k = 0; k < waits && k < MAX_WAIT; k++) push(op, rnd(), rnd(), 1'b0, o);
    if (waits >= MAX_WAIT) begin
      m_tmo = 1'b1;
      timed_out = 1'b1;
      return;
    end
    if (st == 3'd0) begin
      o.pcw = 1'b1;
      o.irw = 1'b1;
    end
    push(op, rnd(), rnd(), 1'b1, o);
  endtask

  // One whole instruction expressed as its list of stages.
  task automatic push_instr(input logic [6:0] op, input logic hr, input logic bc,
                            input int wif, input int wmem, output bit halted);
    obs_t o;
    bit   to;
    halted = 1'b0;
    mem_stage(op, 3'd0, wif, 1'b1, 1'b0, to);
    if (to) begin halted = 1'b1; return; end
    o = blank(3'd1);
    o.b = 2'b10;
    push(op, hr, rnd(), rnd(), o);
    if (op == OP_SYS) begin
      m_instret++;
      halted = hr;
      return;
    end
    if (!is_legal(op)) begin
      m_ill = 1'b1;
      halted = 1'b1;
      return;
    end
    o = blank(3'd2);
    case (op)
      OP_R:         begin o.a = 1'b1; o.op = 2'b10; end
      OP_I:         begin o.a = 1'b1; o.b = 2'b10; o.op = 2'b10; end
      OP_LD, OP_ST: begin o.a = 1'b1; o.b = 2'b10; end
      OP_BR:        begin o.a = 1'b1; o.op = 2'b01; o.ps = 1'b1; o.pcw = bc; end
      OP_JAL:       begin o.ps = 1'b1; o.pcw = 1'b1; end
      default:      begin o.a = 1'b1; o.b = 2'b10; o.pcw = 1'b1; end
    endcase
    push(op, rnd(), bc, rnd(), o);
    if (op == OP_BR) begin
      m_instret++;
      return;
    end
    if (op == OP_LD || op == OP_ST) begin
      mem_stage(op, 3'd3, wmem, op == OP_LD, op == OP_ST, to);
      if (to) begin halted = 1'b1; return; end
      if (op == OP_ST) begin
        m_instret++;
        return;
      end
    end
    o = blank(3'd4);
    o.rw = 1'b1;
    if (op == OP_LD)                         o.wb = 2'b01;
    else if (op == OP_JAL || op == OP_JALR)  o.wb = 2'b10;
    push(op, rnd(), rnd(), rnd(), o);
    m_instret++;
  endtask

  task automatic push_halt(input int n);
    for (int k = 0; k < n; k++) push(7'($urandom), rnd(), rnd(), rnd(), blank(3'd5));
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_queues(input int limit);
    stim_t       s;
    logic [19:0] e;
    int          n = 0;
    while (stim_q.size() > 0 && n < limit) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(posedge clk);
      #1;
      reset = 1'b1;
      opcode = s.op; halt_req = s.hr; alu_bcond = s.bc; mem_ready = s.rdy;
      @(negedge clk);
      check($sformatf("cycle%0d", n), 32'(sample()), 32'(e));
      n++;
    end
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 7'($urandom);
    halt_req = rnd();
    alu_bcond = rnd();
    m_tmo = 1'b0; m_ill = 1'b0; m_cycles = 0; m_instret = 0;
    #1;
    check("reset_async", 32'(sample()), 32'(reset_obs()));
    @(negedge clk);
    check("reset_hold", 32'(sample()), 32'(reset_obs()));
`ifdef PERF_CNT_EN
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    check("reset_instret_cnt", instret_cnt, 32'd0);
`endif
  endtask

  task automatic check_counters();
`ifdef PERF_CNT_EN
    @(posedge clk);
    #1;
    check("cycle_cnt", cycle_cnt, 32'(m_cycles));
    check("instret_cnt", instret_cnt, 32'(m_instret));
`endif
  endtask

  function automatic vec_t mkv(input logic [6:0] op, input logic bc, input logic rdy,
                               input logic [2:0] st, input logic pcw, input logic irw,
                               input logic mr, input logic mw, input logic rw,
                               input logic [1:0] wb, input logic ps);
    vec_t v;
    v.op = op; v.bc = bc; v.rdy = rdy;
    v.exp = {st, pcw, irw, mr, mw, rw, wb, ps};
    return v;
  endfunction

  // ---------------- test sequence ----------------
  vec_t       tbl[29];
  logic [6:0] rand_ops[8];

  initial begin
    bit         h;
    logic [6:0] op;
    int         wif, wmem, term;

    reset = 1'b0; opcode = '0; halt_req = 1'b0; alu_bcond = 1'b0; mem_ready = 1'b0;

    // Directed table: add, beq taken, beq not taken, sw (1 wait), lw, jal, jalr
    tbl[0]  = mkv(OP_R,    0, 1, 3'd0, 1, 1, 1, 0, 0, 2'b00, 0);
    tbl[1]  = mkv(OP_R,    0, 1, 3'd1, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[2]  = mkv(OP_R,    0, 1, 3'd2, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[3]  = mkv(OP_R,    0, 1, 3'd4, 0, 0, 0, 0, 1, 2'b00, 0);
    tbl[4]  = mkv(OP_BR,   0, 1, 3'd0, 1, 1, 1, 0, 0, 2'b00, 0);
    tbl[5]  = mkv(OP_BR,   0, 1, 3'd1, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[6]  = mkv(OP_BR,   1, 1, 3'd2, 1, 0, 0, 0, 0, 2'b00, 1);
    tbl[7]  = mkv(OP_BR,   0, 1, 3'd0, 1, 1, 1, 0, 0, 2'b00, 0);
    tbl[8]  = mkv(OP_BR,   0, 1, 3'd1, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[9]  = mkv(OP_BR,   0, 1, 3'd2, 0, 0, 0, 0, 0, 2'b00, 1);
    tbl[10] = mkv(OP_ST,   0, 1, 3'd0, 1, 1, 1, 0, 0, 2'b00, 0);
    tbl[11] = mkv(OP_ST,   0, 1, 3'd1, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[12] = mkv(OP_ST,   0, 1, 3'd2, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[13] = mkv(OP_ST,   0, 0, 3'd3, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[14] = mkv(OP_ST,   0, 1, 3'd3, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[15] = mkv(OP_LD,   0, 1, 3'd0, 1, 1, 1, 0, 0, 2'b00, 0);
    tbl[16] = mkv(OP_LD,   0, 1, 3'd1, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[17] = mkv(OP_LD,   0, 1, 3'd2, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[18] = mkv(OP_LD,   0, 1, 3'd3, 0, 0, 1, 0, 0, 2'b00, 0);
    tbl[19] = mkv(OP_LD,   0, 1, 3'd4, 0, 0, 0, 0, 1, 2'b01, 0);
    tbl[20] = mkv(OP_JAL,  0, 1, 3'd0, 1, 1, 1, 0, 0, 2'b00, 0);
    tbl[21] = mkv(OP_JAL,  0, 1, 3'd1, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[22] = mkv(OP_JAL,  0, 1, 3'd2, 1, 0, 0, 0, 0, 2'b00, 1);
    tbl[23] = mkv(OP_JAL,  0, 1, 3'd4, 0, 0, 0, 0, 1, 2'b10, 0);
    tbl[24] = mkv(OP_JALR, 0, 1, 3'd0, 1, 1, 1, 0, 0, 2'b00, 0);
    tbl[25] = mkv(OP_JALR, 0, 1, 3'd1, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[26] = mkv(OP_JALR, 0, 1, 3'd2, 1, 0, 0, 0, 0, 2'b00, 0);
    tbl[27] = mkv(OP_JALR, 0, 1, 3'd4, 0, 0, 0, 0, 1, 2'b10, 0);
    tbl[28] = mkv(OP_R,    0, 0, 3'd0, 0, 0, 1, 0, 0, 2'b00, 0);

    do_reset();
    for (int i = 0; i < 29; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      opcode = tbl[i].op; halt_req = 1'b0; alu_bcond = tbl[i].bc; mem_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("tbl%0d", i), 32'(key_fields()), 32'(tbl[i].exp));
    end

    // lw with 3 stalled MEM cycles: WB lands on cycle 8
    do_reset();
    push_instr(OP_LD, 0, 0, 0, 3, h);
    push_instr(OP_R, 0, 0, 0, 0, h);
    run_queues(1000);
    check_counters();

    // ecall with halt_req=1: HALT from cycle 3, absorbing
    do_reset();
    push_instr(OP_SYS, 1, 0, 0, 0, h);
    push_halt(4);
    run_queues(1000);
    check("ecall_is_halted", 32'(is_halted), 32'd1);
    check_counters();

    // ecall with halt_req=0 is a 2-cycle nop
    do_reset();
    push_instr(OP_SYS, 0, 0, 0, 0, h);
    push_instr(OP_I, 0, 0, 0, 0, h);
    run_queues(1000);
    check_counters();

    // Unsupported opcode (LUI) -> illegal_inst, HALT
    do_reset();
    push_instr(7'b0110111, 0, 0, 0, 0, h);
    push_halt(3);
    run_queues(1000);
    check("illegal_flag", 32'(illegal_inst), 32'd1);
    check_counters();

    // IF stalled 11 cycles then ready on the boundary cycle: normal advance;
    // next fetch stalls 12 cycles -> timeout
    do_reset();
    push_instr(OP_R, 0, 0, 11, 0, h);
    push_instr(OP_R, 0, 0, 12, 0, h);
    push_halt(3);
    run_queues(1000);
    check("if_timeout_flag", 32'(mem_timeout), 32'd1);
    check_counters();

    // MEM stalled 12 cycles on a store -> timeout
    do_reset();
    push_instr(OP_ST, 0, 0, 0, 12, h);
    push_halt(3);
    run_queues(1000);
    check("mem_timeout_flag", 32'(mem_timeout), 32'd1);
    check_counters();

    // Reset pulsed low in the middle of a stalled sw access
    do_reset();
    push_instr(OP_ST, 0, 0, 0, 6, h);
    run_queues(5);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_mem_write", 32'(mem_write), 32'd0);
    check("midreset_state", 32'(state), 32'd0);
    do_reset();
    push_instr(OP_R, 0, 0, 0, 0, h);
    run_queues(1000);

    // Randomized instruction streams, each optionally ending in a halt
    rand_ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_SYS};
    for (int b = 0; b < 10; b++) begin
      do_reset();
      for (int i = 0; i < 8; i++) begin
        op   = rand_ops[$urandom_range(0, 7)];
        wif  = ($urandom_range(0, 7) == 0) ? 11 : int'($urandom_range(0, 3));
        wmem = ($urandom_range(0, 7) == 0) ? 11 : int'($urandom_range(0, 3));
        push_instr(op, (op == OP_SYS) ? 1'b0 : rnd(), rnd(), wif, wmem, h);
      end
      term = int'($urandom_range(0, 4));
      h = 1'b0;
      case (term)
        1: push_instr(OP_SYS, 1, 0, 0, 0, h);
        2: begin
          do op = 7'($urandom); while (is_legal(op) || op == OP_SYS);
          push_instr(op, 0, 0, 0, 0, h);
        end
        3: push_instr(OP_I, 0, 0, 12, 0, h);
        4: push_instr(OP_LD, 0, 0, 0, 12, h);
        default: ;
      endcase
      if (h) push_halt(3);
      run_queues(10000);
      check_counters();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
